fp_adder_norm_stage_multi: RTL and testbench
============================================

Name: fp_adder_norm_stage_multi

Overview:
Parametrised, handshaked normalization stage for the FP adder datapath. It takes LANES raw two's-complement adder sums with their aligned (larger) exponents. For each lane it computes the leading-zero count, left-shifts the sum and adjusts the exponent. It also flags zero, underflow and overflow results. It sits between the FP adder add stage and the pack/round stage, and it can stall under backpressure.

Parameters:
- LANES, 2, number of independent lanes sharing one valid/ready handshake.
- EXP_W, 8, exponent width; biased and unsigned.
- MAN_W, 24, mantissa width including the hidden bit. Each input sum is MAN_W+1 bits.
- LZC_W, $clog2(MAN_W), width of the leading-zero count; derived, not to be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input beat valid, all lanes.
- in_ready  out  1  stage can accept a beat.
- in_exponent  in  LANES*EXP_W  per-lane larger exponent; lane i is at [i*EXP_W +: EXP_W].
- in_sum  in  LANES*(MAN_W+1)  per-lane two's-complement sum; bit MAN_W is the sign.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_exponent  out  LANES*EXP_W  normalized exponent.
- out_mantissa  out  LANES*MAN_W  normalized mantissa.
- out_sign  out  LANES  sign bit of in_sum, passed through.
- out_zero  out  LANES  result is exact zero.
- out_underflow  out  LANES  result flushed to zero by underflow.
- out_overflow  out  LANES  exponent saturated.

Behaviour:
- Two-register pipeline, S1 then S2. A beat accepted on cycle t appears on the outputs at cycle t+2 if there is no stall.
- Handshake:
  - A transfer occurs when valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || s2 advances.
  - in_ready = S1 advances; combinational from out_ready, with no skid buffer.
  - Full throughput of 1 beat/cycle when out_ready is held high.
  - While out_valid && !out_ready, all out_* are held stable.
- S1, per lane, on accept:
  - mag = sign ? ~sum[MAN_W-1:0] : sum[MAN_W-1:0].
  - lzc = leading zeros of mag, saturated at MAN_W-1.
  - zero_d = (in_sum == 0).
  - Register sum, lzc, zero_d and exp_p1 = in_exponent + 1, computed at EXP_W+1 bits with no wrap.
- S2, per lane:
  - norm = sum << lzc, kept at MAN_W+1 bits.
  - e = exp_p1 - lzc, signed at EXP_W+2 bits.
  - Apply the first matching rule below, in priority order.
- zero_d:
  - out_zero = 1, exponent = 0, mantissa = 0.
  - out_sign = 0.
- e <= 0:
  - out_underflow = 1, out_zero = 1, exponent = 0, mantissa = 0.
  - out_sign is preserved.
- e >= 2^EXP_W - 1:
  - out_overflow = 1, exponent = all ones, mantissa = 0.
- Otherwise:
  - exponent = e[EXP_W-1:0].
  - mantissa = norm[MAN_W:1].
  - All flags = 0.
- Lanes are fully independent. One lane's flags never affect another lane.
- Reset, with rst_n sampled low at a clock edge:
  - s1_valid and s2_valid are cleared, so out_valid = 0 and in_ready = 1 after the reset edge.
  - All out_* data and flags reset to 0.
  - Beats in flight are discarded, including during a stall.
- Simultaneous accept and output in the same cycle are legal and required.
- Data registers load only on advance; no combinational path from in_* to out_*.

Decomposition:
- Package fp_norm_pkg holds:
  - default EXP_W and MAN_W;
  - a clog2-based LZC_W function;
  - the flag bit positions ZERO, UNDERFLOW, OVERFLOW;
  - exponent all-ones and zero constants.
- Sub-module fp_norm_lzc: purely combinational, parametrised on MAN_W. It implements the sign-conditional magnitude plus priority leading-zero count and is instantiated once per lane via generate.

Test Plan (defaults; lane 0 unless noted; out_ready = 1 unless noted):
1. exp=100, sum=25'h0800000 -> out_valid at t+2, exponent=101, mantissa=24'h400000, all flags 0.
2. exp=100, sum=25'h0000001 -> lzc 23, exponent=78, mantissa=24'h400000. In the same beat, lane 1 exp=5, sum=1 gives out_underflow=1, out_zero=1, exponent=0, mantissa=0.
3. sum=0, exp=77 -> out_zero=1, exponent=0, mantissa=0, out_sign=0. exp=254, sum=25'h0800000 -> out_overflow=1, exponent=8'hFF, mantissa=0.
4. Negative sum 25'h1FFFFFE (-2), exp=50 -> mag=1, lzc 23, exponent=28, out_sign=1, mantissa=(sum<<23)[24:1].
5. Stream 6 back-to-back beats with out_ready low on cycles 3-5 -> in_ready falls once S1 and S2 are full, outputs are held stable, and all 6 beats emerge in order with none lost or duplicated.
6. Assert rst_n=0 for one cycle with both stages full and out_ready=0 -> next cycle out_valid=0, in_ready=1, all outputs 0, and a new beat afterwards emerges with 2-cycle latency.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared constants and helpers for the FP adder normalization stage.
// Holds default widths, flag bit positions and exponent constants.
package fp_norm_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 24;

  localparam int ZERO      = 0;
  localparam int UNDERFLOW = 1;
  localparam int OVERFLOW  = 2;
  localparam int FLAG_W    = 3;

  localparam logic [DEF_EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [DEF_EXP_W-1:0] EXP_ZERO = '0;

  function automatic int lzc_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/fp_norm_lzc.sv
// Sign-conditional magnitude and priority leading-zero count.
// i_sum: two's-complement sum (MSB is sign); o_lzc: count, saturated at MAN_W-1.
module fp_norm_lzc
  import fp_norm_pkg::*;
#(
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [MAN_W:0]            i_sum,
  output logic [lzc_w(MAN_W)-1:0]   o_lzc
);

  localparam int LZC_W = lzc_w(MAN_W);

  logic [MAN_W-1:0] w_mag;

  // One's complement is enough for negatives: it makes the
  // redundant sign copies disappear from the top of the word.
  assign w_mag = i_sum[MAN_W] ? ~i_sum[MAN_W-1:0]
                              : i_sum[MAN_W-1:0];

  // Scan upward so the highest set bit wins; an all-zero
  // magnitude keeps the saturated default.
  always_comb begin
    o_lzc = LZC_W'(MAN_W - 1);
    for (int i = 0; i < MAN_W; i++) begin
      if (w_mag[i]) o_lzc = LZC_W'(MAN_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_adder_norm_stage_multi.sv
// Multi-lane two-stage handshaked normalization stage for the FP adder.
// in_*: valid/ready beat of LANES sums+exponents; out_*: normalized exp/mantissa, sign, zero/underflow/overflow flags.
module fp_adder_norm_stage_multi
  import fp_norm_pkg::*;
#(
  parameter int LANES = 2,
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*EXP_W-1:0]     in_exponent,
  input  logic [LANES*(MAN_W+1)-1:0] in_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*EXP_W-1:0]     out_exponent,
  output logic [LANES*MAN_W-1:0]     out_mantissa,
  output logic [LANES-1:0]           out_sign,
  output logic [LANES-1:0]           out_zero,
  output logic [LANES-1:0]           out_underflow,
  output logic [LANES-1:0]           out_overflow
);

  localparam int LZC_W = lzc_w(MAN_W);
  localparam int SW    = MAN_W + 1;

  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_s1_load = w_s1_adv && in_valid;
  assign w_s2_load = w_s2_adv && r_s1_valid;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SW-1:0]          w_sum;
    logic [EXP_W-1:0]       w_exp;
    logic [LZC_W-1:0]       w_lzc;

    logic [SW-1:0]          r_sum;
    logic [LZC_W-1:0]       r_lzc;
    logic                   r_zero_d;
    logic [EXP_W:0]         r_exp_p1;

    logic signed [EXP_W+1:0] w_e;
    logic                   w_uf;
    logic                   w_ov;
    logic [MAN_W-1:0]       w_man;

    logic [EXP_W-1:0]       w_oexp;
    logic [MAN_W-1:0]       w_oman;
    logic                   w_osign;
    logic [FLAG_W-1:0]      w_flags;

    logic [EXP_W-1:0]       r_oexp;
    logic [MAN_W-1:0]       r_oman;
    logic                   r_osign;
    logic [FLAG_W-1:0]      r_flags;

    assign w_sum = in_sum[g*SW +: SW];
    assign w_exp = in_exponent[g*EXP_W +: EXP_W];

    fp_norm_lzc #(
      .MAN_W (MAN_W)
    ) u_lzc (
      .i_sum (w_sum),
      .o_lzc (w_lzc)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sum    <= '0;
        r_lzc    <= '0;
        r_zero_d <= 1'b0;
        r_exp_p1 <= '0;
      end else if (w_s1_load) begin
        r_sum    <= w_sum;
        r_lzc    <= w_lzc;
        r_zero_d <= (w_sum == '0);
        r_exp_p1 <= {1'b0, w_exp} + (EXP_W+1)'(1);
      end
    end

    // Exponent math is two bits wider than EXP_W so both the
    // +1 carry and a negative result stay representable.
    assign w_e = $signed({1'b0, r_exp_p1})
               - $signed({{(EXP_W+2-LZC_W){1'b0}}, r_lzc});

    assign w_uf = w_e[EXP_W+1] || (w_e == '0);
    assign w_ov = !w_e[EXP_W+1]
               && (w_e[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});

    // Shift at sum width, then drop the LSB: the top MAN_W bits
    // of the normalized sum form the mantissa.
    assign w_man = MAN_W'((r_sum << r_lzc) >> 1);

    always_comb begin
      w_oexp  = w_e[EXP_W-1:0];
      w_oman  = w_man;
      w_osign = r_sum[MAN_W];
      w_flags = '0;
      if (r_zero_d) begin
        w_oexp        = '0;
        w_oman        = '0;
        w_osign       = 1'b0;
        w_flags[ZERO] = 1'b1;
      end else if (w_uf) begin
        w_oexp             = '0;
        w_oman             = '0;
        w_flags[ZERO]      = 1'b1;
        w_flags[UNDERFLOW] = 1'b1;
      end else if (w_ov) begin
        w_oexp            = '1;
        w_oman            = '0;
        w_flags[OVERFLOW] = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_oexp  <= '0;
        r_oman  <= '0;
        r_osign <= 1'b0;
        r_flags <= '0;
      end else if (w_s2_load) begin
        r_oexp  <= w_oexp;
        r_oman  <= w_oman;
        r_osign <= w_osign;
        r_flags <= w_flags;
      end
    end

    assign out_exponent[g*EXP_W +: EXP_W] = r_oexp;
    assign out_mantissa[g*MAN_W +: MAN_W] = r_oman;
    assign out_sign[g]      = r_osign;
    assign out_zero[g]      = r_flags[ZERO];
    assign out_underflow[g] = r_flags[UNDERFLOW];
    assign out_overflow[g]  = r_flags[OVERFLOW];
  end

endmodule

// File: tb/tb_fp_adder_norm_stage_multi.sv
// Scoreboard bench for fp_adder_norm_stage_multi.
// Directed two-lane vectors with hand-computed results.
module tb_fp_adder_norm_stage_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_exponent;
  logic [49:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_exponent;
  logic [47:0] out_mantissa;
  logic [1:0]  out_sign;
  logic [1:0]  out_zero;
  logic [1:0]  out_underflow;
  logic [1:0]  out_overflow;

  fp_adder_norm_stage_multi #(
    .LANES (2),
    .EXP_W (8),
    .MAN_W (24)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_exponent   (in_exponent),
    .in_sum        (in_sum),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_exponent  (out_exponent),
    .out_mantissa  (out_mantissa),
    .out_sign      (out_sign),
    .out_zero      (out_zero),
    .out_underflow (out_underflow),
    .out_overflow  (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] m;
    logic        s, z, u, o;
  } lane_t;

  typedef struct {
    logic [15:0] e;
    logic [47:0] m;
    logic [1:0]  s, z, u, o;
    bit          lat;
    int          acc;
  } beat_t;

  beat_t q[$];
  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit saw_block = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic lane_t L(input logic [7:0] e, input logic [23:0] m,
                              input logic s, z, u, o);
    lane_t r;
    r.e = e; r.m = m; r.s = s; r.z = z; r.u = u; r.o = o;
    return r;
  endfunction

  // Caller sits just after a posedge; returns just after the posedge
  // on which the beat was taken.
  task automatic send(input logic [7:0] e0, input logic [24:0] s0,
                      input logic [7:0] e1, input logic [24:0] s1,
                      input lane_t x0, input lane_t x1, input bit lat);
    beat_t b;
    int t;
    in_valid    = 1'b1;
    in_exponent = {e1, e0};
    in_sum      = {s1, s0};
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 1, 0);
    else begin
      b.e = {x1.e, x0.e};
      b.m = {x1.m, x0.m};
      b.s = {x1.s, x0.s};
      b.z = {x1.z, x0.z};
      b.u = {x1.u, x0.u};
      b.o = {x1.o, x0.o};
      b.lat = lat;
      b.acc = cyc;
      q.push_back(b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_out_valid"}, 80'(out_valid), 0);
    chk({nm, "_in_ready"}, 80'(in_ready), 1);
    chk({nm, "_outputs"}, {out_exponent, out_mantissa, out_sign,
        out_zero, out_underflow, out_overflow}, 0);
  endtask

  logic [71:0] h_snap;
  bit          h_v = 0;

  always @(negedge clk) begin
    beat_t b;
    if (in_valid && !in_ready) saw_block = 1;
    if (!rst_n) h_v = 0;
    else begin
      if (h_v && out_valid)
        chk("hold_stable", {out_exponent, out_mantissa, out_sign,
            out_zero, out_underflow, out_overflow}, h_snap);
      h_v = out_valid && !out_ready;
      h_snap = {out_exponent, out_mantissa, out_sign,
                out_zero, out_underflow, out_overflow};
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          b = q.pop_front();
          chk("exponent",  80'(out_exponent),  80'(b.e));
          chk("mantissa",  80'(out_mantissa),  80'(b.m));
          chk("sign",      80'(out_sign),      80'(b.s));
          chk("zero",      80'(out_zero),      80'(b.z));
          chk("underflow", 80'(out_underflow), 80'(b.u));
          chk("overflow",  80'(out_overflow),  80'(b.o));
          if (b.lat) chk("latency", 80'(cyc - b.acc), 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_exponent = '0;
    in_sum      = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;

    // normal and lzc=1
    send(8'd100, 25'h0800000, 8'd10, 25'h0400000,
         L(8'd101, 24'h400000, 0, 0, 0, 0),
         L(8'd10,  24'h400000, 0, 0, 0, 0), 1);
    // lzc 23; lane 1 underflows
    send(8'd100, 25'h0000001, 8'd5, 25'h0000001,
         L(8'd78, 24'h400000, 0, 0, 0, 0),
         L(8'd0,  24'h0,      0, 1, 1, 0), 0);
    // exact zero; overflow
    send(8'd77, 25'h0, 8'd254, 25'h0800000,
         L(8'd0,   24'h0, 0, 1, 0, 0),
         L(8'hFF,  24'h0, 0, 0, 0, 1), 0);
    // -2; -1 underflows with sign kept
    send(8'd50, 25'h1FFFFFE, 8'd3, 25'h1FFFFFF,
         L(8'd28, 24'h800000, 1, 0, 0, 0),
         L(8'd0,  24'h0,      1, 1, 1, 0), 0);
    // e == 0 underflows; e == 1 is normal
    send(8'd22, 25'h0000001, 8'd23, 25'h0000001,
         L(8'd0, 24'h0,      0, 1, 1, 0),
         L(8'd1, 24'h400000, 0, 0, 0, 0), 0);
    // e == 254 normal; negative e == 255 overflows
    send(8'd253, 25'h0800000, 8'd254, 25'h1000000,
         L(8'd254, 24'h400000, 0, 0, 0, 0),
         L(8'hFF,  24'h0,      1, 0, 0, 1), 0);
    // negative lzc 2; zero input exponent
    send(8'd100, 25'h1C00000, 8'd0, 25'h0800000,
         L(8'd99, 24'h800000, 1, 0, 0, 0),
         L(8'd1,  24'h400000, 0, 0, 0, 0), 0);

    repeat (4) @(posedge clk);
    #1;

    // six-beat stream with a three-cycle stall
    saw_block = 0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(8'(20 + k), 25'h0800000, 8'd40,
               25'h0800000 | 25'(k << 1),
               L(8'(21 + k), 24'h400000, 0, 0, 0, 0),
               L(8'd41, 24'h400000 | 24'(k), 0, 0, 0, 0), 0);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    chk("in_ready_fell", 80'(saw_block), 1);
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stream_drained", 80'(q.size()), 0);

    // fill both stages under stall, then reset
    out_ready = 1'b0;
    send(8'd60, 25'h0800000, 8'd61, 25'h0800000,
         L(8'd61, 24'h400000, 0, 0, 0, 0),
         L(8'd62, 24'h400000, 0, 0, 0, 0), 0);
    send(8'd70, 25'h0800000, 8'd71, 25'h0800000,
         L(8'd71, 24'h400000, 0, 0, 0, 0),
         L(8'd72, 24'h400000, 0, 0, 0, 0), 0);
    chk("full_before_reset", {78'd0, out_valid, in_ready}, 80'b10);
    q.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("flush");
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd100, 25'h0000001, 8'd200, 25'h0400000,
         L(8'd78,  24'h400000, 0, 0, 0, 0),
         L(8'd200, 24'h400000, 0, 0, 0, 0), 1);

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("final_drained", 80'(q.size()), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
